ball_ctrl: RTL

Sequencing controller for the ball position counters. It generates the rate-limited step enable and the per-axis up/down direction bits. It reflects the ball off the playfield walls, the paddle and bricks, and detects a lost ball. It owns the position counters' active-low synchronous reset, so it can re-serve the ball. It sits between the collision/paddle logic and the ball position block.

---
 rtl/ball_ctrl_if.sv | 28 ++
 rtl/ball_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ball_ctrl_if.sv
// Handshake/bus bundle between the ball controller and its neighbours: serve request,
// position/paddle/brick inputs, and the step/direction/reset outputs to the position counters.
interface ball_ctrl_if;
  logic       launch;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] paddle_x;
  logic       brick_hit;
  logic       brick_side;
  logic       step;
  logic       x_du;
  logic       y_du;
  logic       pos_resetn;
  logic       lost;
  logic       running;

  // Environment side: drives the controller inputs, observes its outputs.
  modport master (
    output launch, x, y, paddle_x, brick_hit, brick_side,
    input  step, x_du, y_du, pos_resetn, lost, running
  );

  // Controller side.
  modport slave (
    input  launch, x, y, paddle_x, brick_hit, brick_side,
    output step, x_du, y_du, pos_resetn, lost, running
  );
endinterface

// File: rtl/ball_ctrl.sv
// Ball sequencing controller: rate-limited step enable, per-axis direction bits, wall/paddle/
// brick reflection, lost-ball detection and the position counters' synchronous reset.
module ball_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned BALL_W   = 4,
  parameter int unsigned PADDLE_Y = 460,
  parameter int unsigned PADDLE_W = 64
) (
  input logic        clk,
  input logic        reset,
  ball_ctrl_if.slave bus
);

  // Three bits so spare encodings exist and are steered back to StInit.
  typedef enum logic [2:0] {
    StInit = 3'd0,
    StWait = 3'd1,
    StRun  = 3'd2,
    StLost = 3'd3
  } state_e;

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  // Directions update on the edge entering the cnt==TICK_DIV-1 cycle, one cycle ahead of step.
  localparam logic [CntW-1:0] CntPre  = CntW'(TICK_DIV - 2);

  localparam logic [10:0] XLim   = 11'(X_MAX - BALL_W);
  localparam logic [10:0] YLim   = 11'(Y_MAX - BALL_W);
  localparam logic [10:0] PadTop = 11'(PADDLE_Y);
  localparam logic [10:0] BallW  = 11'(BALL_W);
  localparam logic [10:0] PadW   = 11'(PADDLE_W);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            step_q;
  logic            x_du_q;
  logic            y_du_q;
  logic            pos_resetn_q;
  logic            lost_q;
  logic            running_q;
  logic            pend_q;
  logic            pend_side_q;

  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] px_w;
  logic        is_dec;
  logic        x_rule;
  logic        y_rule;
  logic        floor_hit;
  logic        x_du_dec;
  logic        y_du_dec;

  assign x_w  = {1'b0, bus.x};
  assign y_w  = {1'b0, bus.y};
  assign px_w = {1'b0, bus.paddle_x};

  // Reflection rules on the current position; wall/paddle rules override a same-axis brick flip.
  always_comb begin
    is_dec    = (state_q == StRun) && (cnt_q == CntPre);
    x_rule    = (x_du_q && (x_w >= XLim)) || (!x_du_q && (x_w == '0));
    y_rule    = (!y_du_q && (y_w == '0)) ||
                (y_du_q && ((y_w + BallW) == PadTop) && ((x_w + BallW) > px_w) &&
                 (x_w < (px_w + PadW)));
    floor_hit = y_du_q && (y_w >= YLim);
    x_du_dec  = x_du_q;
    y_du_dec  = y_du_q;
    if (x_rule || (pend_q && pend_side_q)) begin
      x_du_dec = !x_du_q;
    end
    if (y_rule || (pend_q && !pend_side_q)) begin
      y_du_dec = !y_du_q;
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      x_du_q       <= 1'b1;
      y_du_q       <= 1'b1;
      pos_resetn_q <= 1'b0;
      lost_q       <= 1'b0;
      running_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_side_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      lost_q <= 1'b0;
      case (state_q)
        StInit: begin
          state_q      <= StWait;
          pos_resetn_q <= 1'b1;
          x_du_q       <= 1'b1;
          y_du_q       <= 1'b1;
          cnt_q        <= '0;
          running_q    <= 1'b0;
          pend_q       <= 1'b0;
        end
        StWait: begin
          pend_q <= 1'b0;
          if (bus.launch) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          cnt_q  <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
          step_q <= (cnt_q == CntLast);
          if (bus.brick_hit) begin
            pend_q      <= 1'b1;
            pend_side_q <= bus.brick_side;
          end
          if (is_dec) begin
            if (floor_hit) begin
              state_q      <= StLost;
              lost_q       <= 1'b1;
              pos_resetn_q <= 1'b0;
              running_q    <= 1'b0;
              pend_q       <= 1'b0;
            end else begin
              x_du_q <= x_du_dec;
              y_du_q <= y_du_dec;
              // A hit landing on the decision edge itself waits for the next decision.
              pend_q <= bus.brick_hit;
            end
          end
        end
        StLost: begin
          state_q      <= StInit;
          pos_resetn_q <= 1'b0;
          x_du_q       <= 1'b1;
          y_du_q       <= 1'b1;
          pend_q       <= 1'b0;
        end
        default: begin
          state_q      <= StInit;
          pos_resetn_q <= 1'b0;
          running_q    <= 1'b0;
          pend_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step       = step_q;
  assign bus.x_du       = x_du_q;
  assign bus.y_du       = y_du_q;
  assign bus.pos_resetn = pos_resetn_q;
  assign bus.lost       = lost_q;
  assign bus.running    = running_q;

endmodule
